and_mask_arbiter: RTL and testbench

- Shares one W-bit AND-mask unit (y = data & mask) between N requesters, using round-robin arbitration.
- Holds a configurable mask register and an enable bit.
- When enable is 0, the unit is in bypass and the mask is treated as all-ones (y = data).
- Sits between several datapath clients and the mask unit. Returns a registered result with a requester tag over a valid/ready handshake.

---
 rtl/and_mask_arbiter.sv | 130 +++++++++++++
 tb/tb_and_mask_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/and_mask_arbiter.sv
// Round-robin arbiter sharing one W-bit AND-mask unit among N requesters.
// Returns a registered, tagged result over a valid/ready handshake.
module and_mask_arbiter #(
  parameter int N   = 4,
  parameter int W   = 16,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  output logic [N-1:0]   gnt,
  input  logic           cfg_we,
  input  logic [W-1:0]   cfg_mask,
  input  logic           cfg_en,
  output logic [W-1:0]   mask_q,
  output logic           en_q,
  output logic [W-1:0]   y,
  output logic [IDW-1:0] y_id,
  output logic           y_valid,
  input  logic           y_ready,
  output logic           busy,
  output logic           dbg_state,
  output logic [IDW-1:0] dbg_rr_ptr
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  logic           r_state;
  logic           w_next_state;
  logic [W-1:0]   r_mask;
  logic           r_en;
  logic [W-1:0]   r_y;
  logic [IDW-1:0] r_y_id;
  logic           r_y_valid;
  logic [IDW-1:0] r_rr_ptr;

  logic           w_found;
  logic [IDW-1:0] w_win;
  logic [N-1:0]   w_pick;
  logic [W-1:0]   w_sel_data;
  logic [W-1:0]   w_mask_eff;
  logic [IDW-1:0] w_rr_next;
  logic           w_grant;

  // Search starts at r_rr_ptr and wraps, so the last winner has lowest priority.
  always_comb begin : arb
    int idx;
    idx        = 0;
    w_found    = 1'b0;
    w_win      = '0;
    w_pick     = '0;
    w_sel_data = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(r_rr_ptr) + k) % N;
      if (!w_found && req[idx]) begin
        w_found     = 1'b1;
        w_win       = IDW'(idx);
        w_pick[idx] = 1'b1;
        w_sel_data  = data[idx*W +: W];
      end
    end
  end

  assign w_mask_eff = r_en ? r_mask : {W{1'b1}};
  assign w_rr_next  = (w_win == IDW'(N - 1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Valid/ready: y_valid rises the edge after a grant and holds, together with
  // y and y_id, until the edge where y_ready is sampled high; that edge
  // completes the transfer and no grant is issued in the same cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_next_state = ST_HOLD;
      ST_HOLD: if (y_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt     = '0;
    w_grant = 1'b0;
    busy    = 1'b0;
    if (r_state == ST_IDLE) begin
      gnt     = w_pick;
      w_grant = w_found;
    end else begin
      busy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask    <= {W{1'b1}};
      r_en      <= 1'b1;
      r_y       <= '0;
      r_y_id    <= '0;
      r_y_valid <= 1'b0;
      r_rr_ptr  <= '0;
    end else begin
      if (cfg_we) begin
        r_mask <= cfg_mask;
        r_en   <= cfg_en;
      end
      if (w_grant) begin
        r_y       <= w_sel_data & w_mask_eff;
        r_y_id    <= w_win;
        r_y_valid <= 1'b1;
        r_rr_ptr  <= w_rr_next;
      end else if (r_state == ST_HOLD && y_ready) begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign mask_q     = r_mask;
  assign en_q       = r_en;
  assign y          = r_y;
  assign y_id       = r_y_id;
  assign y_valid    = r_y_valid;
  assign dbg_state  = r_state;
  assign dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_and_mask_arbiter.sv
// Directed bench for and_mask_arbiter: a vector table for single transactions
// plus hand-written sequences for fairness, backpressure, config and reset.
module tb_and_mask_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] data;
  logic [3:0]  gnt;
  logic        cfg_we;
  logic [15:0] cfg_mask;
  logic        cfg_en;
  logic [15:0] mask_q;
  logic        en_q;
  logic [15:0] y;
  logic [1:0]  y_id;
  logic        y_valid;
  logic        y_ready;
  logic        busy;
  logic        dbg_state;
  logic [1:0]  dbg_rr_ptr;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  and_mask_arbiter #(.N(4), .W(16), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .gnt(gnt),
    .cfg_we(cfg_we), .cfg_mask(cfg_mask), .cfg_en(cfg_en),
    .mask_q(mask_q), .en_q(en_q), .y(y), .y_id(y_id), .y_valid(y_valid),
    .y_ready(y_ready), .busy(busy), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] data;
    logic        cfg_we;
    logic [15:0] cfg_mask;
    logic        cfg_en;
    logic [3:0]  exp_gnt;
    logic [15:0] exp_y;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one config write as its own cycle
  task automatic cfg_write(input logic [15:0] m, input logic e);
    cfg_we = 1'b1; cfg_mask = m; cfg_en = e;
    tick();
    cfg_we = 1'b0;
  endtask

  // check the held result against the scoreboard, then accept it
  task automatic sb_accept(input string name, input logic [1:0] id);
    logic [15:0] e;
    chk({name, "_valid"}, 32'(y_valid), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    chk({name, "_gnt_hold"}, 32'(gnt), 32'd0);
    chk({name, "_id"}, 32'(y_id), 32'(id));
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s_sb: result with empty expected queue", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_y"}, 32'(y), 32'(e));
    end
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    chk({name, "_drop"}, 32'(y_valid), 32'd0);
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // table: cfg (if any) is written one cycle before the request
    vecs[0] = '{4'b0001, 64'h0000_0000_0000_A5A5, 1'b0, 16'h0000, 1'b0, 4'b0001, 16'hA5A5, 2'd0};
    vecs[1] = '{4'b0100, 64'h0000_1234_0000_0000, 1'b1, 16'h0F0F, 1'b1, 4'b0100, 16'h0204, 2'd2};
    vecs[2] = '{4'b0100, 64'h0000_1234_0000_0000, 1'b1, 16'h0F0F, 1'b0, 4'b0100, 16'h1234, 2'd2};
    vecs[3] = '{4'b0011, 64'h0000_0000_FF00_00FF, 1'b1, 16'hFFFF, 1'b1, 4'b0001, 16'h00FF, 2'd0};
    vecs[4] = '{4'b0011, 64'h0000_0000_FF00_00FF, 1'b0, 16'h0000, 1'b0, 4'b0010, 16'hFF00, 2'd1};
    vecs[5] = '{4'b1001, 64'hABCD_0000_0000_1111, 1'b1, 16'hF0F0, 1'b1, 4'b1000, 16'hA0C0, 2'd3};
    vecs[6] = '{4'b1000, 64'hFFFF_0000_0000_0000, 1'b0, 16'h0000, 1'b0, 4'b1000, 16'hF0F0, 2'd3};

    rst_n = 1'b0; req = '0; data = '0; cfg_we = 1'b0; cfg_mask = '0; cfg_en = 1'b0;
    y_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(y_valid), 32'd0);
    chk("rst_mask", 32'(mask_q), 32'hFFFF);
    chk("rst_en", 32'(en_q), 32'd1);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ptr", 32'(dbg_rr_ptr), 32'd0);
    #10 rst_n = 1'b1;
    tick();
    chk("idle_noreq_gnt", 32'(gnt), 32'd0);
    chk("idle_noreq_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].cfg_we) cfg_write(vecs[i].cfg_mask, vecs[i].cfg_en);
      req = vecs[i].req; data = vecs[i].data;
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
      exp_q.push_back(vecs[i].exp_y);
      tick();
      req = '0;
      sb_accept($sformatf("v%0d", i), vecs[i].exp_id);
    end

    // round-robin with every requester pending and the consumer always ready
    cfg_write(16'hFFFF, 1'b1);
    req = 4'b1111;
    data = 64'h3333_2222_1111_0000;
    for (int j = 0; j < 5; j++) begin
      logic [1:0] id;
      id = 2'(j % 4);
      #1;
      chk($sformatf("rr%0d_gnt", j), 32'(gnt), 32'(4'b0001 << id));
      exp_q.push_back(16'(id) * 16'h1111);
      tick();
      sb_accept($sformatf("rr%0d", j), id);
    end
    req = '0;

    // backpressure: rr_ptr is 1, requesters 1 and 3 pending
    req = 4'b1010; data = 64'h3333_0000_1111_0000;
    #1;
    chk("bp_gnt", 32'(gnt), 32'b0010);
    exp_q.push_back(16'h1111);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_y", c), 32'(y), 32'h1111);
      chk($sformatf("bp%0d_id", c), 32'(y_id), 32'd1);
      chk($sformatf("bp%0d_gnt", c), 32'(gnt), 32'd0);
      chk($sformatf("bp%0d_busy", c), 32'(busy), 32'd1);
      tick();
    end
    sb_accept("bp_rel", 2'd1);
    chk("bp_next_gnt", 32'(gnt), 32'b1000);
    exp_q.push_back(16'h3333);
    tick();
    req = '0;
    sb_accept("bp_next", 2'd3);

    // same-cycle config uses the old mask; following op uses the new one
    req = 4'b0001; data = 64'h0000_0000_0000_FFFF;
    cfg_we = 1'b1; cfg_mask = 16'h00FF; cfg_en = 1'b1;
    #1;
    chk("sc_gnt", 32'(gnt), 32'b0001);
    exp_q.push_back(16'hFFFF);
    tick();
    req = '0; cfg_we = 1'b0;
    chk("sc_mask", 32'(mask_q), 32'h00FF);
    sb_accept("sc_old", 2'd0);
    req = 4'b0001;
    exp_q.push_back(16'h00FF);
    tick();
    req = '0;
    cfg_write(16'h0000, 1'b1);
    chk("hold_cfg_mask", 32'(mask_q), 32'h0000);
    sb_accept("sc_new", 2'd0);

    // asynchronous reset while holding a result
    cfg_write(16'hFFFF, 1'b1);
    req = 4'b0100; data = 64'h0000_BEEF_0000_0000;
    tick();
    req = '0;
    chk("ar_pre_valid", 32'(y_valid), 32'd1);
    chk("ar_pre_ptr", 32'(dbg_rr_ptr), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(y_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_ptr", 32'(dbg_rr_ptr), 32'd0);
    chk("ar_y", 32'(y), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("ar_state", 32'(dbg_state), 32'd0);
    chk("ar_noreplay", 32'(y_valid), 32'd0);
    req = 4'b1111; data = 64'h4444_3333_2222_1111;
    #1;
    chk("ar_gnt", 32'(gnt), 32'b0001);
    exp_q.push_back(16'h1111);
    tick();
    req = '0;
    sb_accept("ar_first", 2'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
